// File: rtl/smi_rx_arbiter.sv
// SMI read-channel arbiter: round-robin bursts from the 0.9/2.4 GHz RX FIFOs, bytes MSB-first per SOE.
// Optional SMI_ARB_HEADER_EN: a channel-tag byte {4'hA,3'b000,ch} precedes each burst.
module smi_rx_arbiter #(
  parameter int BURST_WORDS = 16,
  parameter int WORD_W      = 32
) (
  input  logic              i_sys_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_fifo_09_empty,
  input  logic [WORD_W-1:0] i_fifo_09_data,
  output logic              o_fifo_09_pull,
  input  logic              i_fifo_24_empty,
  input  logic [WORD_W-1:0] i_fifo_24_data,
  output logic              o_fifo_24_pull,
  input  logic              i_smi_soe_se,
  output logic [7:0]        o_smi_data_out,
  output logic              o_smi_read_req,
  output logic              o_active_ch,
  output logic              o_underrun_err
);

  localparam int CNT_W = 7;
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PULL,
    S_LOAD,
    S_SHIFT
`ifdef SMI_ARB_HEADER_EN
    , S_HEADER
`endif
  } state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                active_ch_q, active_ch_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [CNT_W-1:0]    burst_cnt_q, burst_cnt_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [7:0]          data_out_q, data_out_d;
  logic                read_req_q, read_req_d;
  logic                underrun_q, underrun_d;
  logic                soe_q1, soe_q2;

  logic                soe_rise;
  logic                gnt_empty;
  logic [WORD_W-1:0]   gnt_data;
  logic                any_ready;
  logic                next_ch;
  logic [1:0]          idx_m1;
  logic                in_data_state;

  assign soe_rise  = soe_q1 & ~soe_q2;
  assign gnt_empty = active_ch_q ? i_fifo_24_empty : i_fifo_09_empty;
  assign gnt_data  = active_ch_q ? i_fifo_24_data : i_fifo_09_data;
  assign any_ready = ~i_fifo_09_empty | ~i_fifo_24_empty;
  assign idx_m1    = byte_idx_q - 2'd1;

  // Tie goes to the channel not served last; otherwise the only ready one.
  assign next_ch = (~i_fifo_09_empty & ~i_fifo_24_empty)
                 ? ~last_grant_q : ~i_fifo_24_empty;

`ifdef SMI_ARB_HEADER_EN
  assign in_data_state = (state_q == S_SHIFT) | (state_q == S_HEADER);
`else
  assign in_data_state = (state_q == S_SHIFT);
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    active_ch_d  = active_ch_q;
    byte_idx_d   = byte_idx_q;
    burst_cnt_d  = burst_cnt_q;
    shreg_d      = shreg_q;
    data_out_d   = data_out_q;
    read_req_d   = read_req_q;
    underrun_d   = underrun_q | (soe_rise & ~in_data_state);

    unique case (state_q)
      S_IDLE: begin
        if (i_enable && any_ready) begin
          active_ch_d  = next_ch;
          last_grant_d = next_ch;
          burst_cnt_d  = '0;
`ifdef SMI_ARB_HEADER_EN
          data_out_d   = {4'hA, 3'b000, next_ch};
          read_req_d   = 1'b1;
          state_d      = S_HEADER;
`else
          state_d      = S_PULL;
`endif
        end
      end
`ifdef SMI_ARB_HEADER_EN
      S_HEADER: begin
        if (soe_rise) begin
          data_out_d = '0;
          read_req_d = 1'b0;
          state_d    = S_PULL;
        end
      end
`endif
      S_PULL: begin
        burst_cnt_d = burst_cnt_q + 1'b1;
        state_d     = S_LOAD;
      end
      S_LOAD: begin
        shreg_d    = gnt_data;
        data_out_d = gnt_data[WORD_W-1 -: 8];
        byte_idx_d = 2'd3;
        read_req_d = 1'b1;
        state_d    = S_SHIFT;
      end
      S_SHIFT: begin
        if (soe_rise) begin
          if (byte_idx_q != 2'd0) begin
            byte_idx_d = idx_m1;
            data_out_d = shreg_q[{idx_m1, 3'b000} +: 8];
          end else begin
            data_out_d = '0;
            read_req_d = 1'b0;
            // Empty flag is only consulted here, at the word boundary.
            if ((burst_cnt_q < BURST_MAX) && !gnt_empty && i_enable)
              state_d = S_PULL;
            else
              state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      active_ch_q  <= 1'b0;
      byte_idx_q   <= 2'd3;
      burst_cnt_q  <= '0;
      shreg_q      <= '0;
      data_out_q   <= '0;
      read_req_q   <= 1'b0;
      underrun_q   <= 1'b0;
      soe_q1       <= 1'b0;
      soe_q2       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      active_ch_q  <= active_ch_d;
      byte_idx_q   <= byte_idx_d;
      burst_cnt_q  <= burst_cnt_d;
      shreg_q      <= shreg_d;
      data_out_q   <= data_out_d;
      read_req_q   <= read_req_d;
      underrun_q   <= underrun_d;
      soe_q1       <= i_smi_soe_se;
      soe_q2       <= soe_q1;
    end
  end

  assign o_fifo_09_pull = (state_q == S_PULL) & ~active_ch_q;
  assign o_fifo_24_pull = (state_q == S_PULL) & active_ch_q;
  assign o_smi_data_out = data_out_q;
  assign o_smi_read_req = read_req_q;
  assign o_active_ch    = active_ch_q;
  assign o_underrun_err = underrun_q;

endmodule

// File: tb/tb_smi_rx_arbiter.sv
// Bench for smi_rx_arbiter: directed cases plus random FIFO loads against a byte-stream model.
// Honours SMI_ARB_HEADER_EN by expecting a tag byte at the start of each burst.
module tb_smi_rx_arbiter;

  localparam int BW = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        soe = 1'b0;
  logic        e09, e24;
  logic [31:0] d09 = '0;
  logic [31:0] d24 = '0;
  logic        p09, p24;
  logic [7:0]  dout;
  logic        rreq, ach, uerr;

  logic [31:0] mem09 [256];
  logic [31:0] mem24 [256];
  int wr09 = 0, rd09 = 0, wr24 = 0, rd24 = 0;
  int pulls09 = 0, pulls24 = 0, bad_pulls = 0;
  int n_checks = 0, n_pass = 0;

  logic [31:0] m09 [$];
  logic [31:0] m24 [$];
  logic [7:0]  eb [$];
  bit          ec [$];
  bit          mlg;

  assign e09 = (wr09 == rd09);
  assign e24 = (wr24 == rd24);

  always #5 clk = ~clk;

  smi_rx_arbiter #(.BURST_WORDS(BW), .WORD_W(32)) dut (
    .i_sys_clk       (clk),
    .i_reset         (rst),
    .i_enable        (en),
    .i_fifo_09_empty (e09),
    .i_fifo_09_data  (d09),
    .o_fifo_09_pull  (p09),
    .i_fifo_24_empty (e24),
    .i_fifo_24_data  (d24),
    .o_fifo_24_pull  (p24),
    .i_smi_soe_se    (soe),
    .o_smi_data_out  (dout),
    .o_smi_read_req  (rreq),
    .o_active_ch     (ach),
    .o_underrun_err  (uerr)
  );

  // FIFO models: data valid the cycle after the pop strobe.
  always @(posedge clk) begin
    if (p09) begin
      pulls09 <= pulls09 + 1;
      if (wr09 == rd09) bad_pulls <= bad_pulls + 1;
      else begin
        d09  <= mem09[rd09];
        rd09 <= rd09 + 1;
      end
    end
    if (p24) begin
      pulls24 <= pulls24 + 1;
      if (wr24 == rd24) bad_pulls <= bad_pulls + 1;
      else begin
        d24  <= mem24[rd24];
        rd24 <= rd24 + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push09(input logic [31:0] w);
    mem09[wr09] = w;
    wr09++;
  endtask

  task automatic push24(input logic [31:0] w);
    mem24[wr24] = w;
    wr24++;
  endtask

  // Host read: wait for read_req, sample, then strobe SOE once.
  task automatic read_byte(output logic [7:0] b, output logic c);
    int i;
    i = 0;
    while (!rreq && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (!rreq) begin
      n_checks++;
      $error("FAIL read_timeout observed=0 expected=1");
      b = 'x;
      c = 1'bx;
      return;
    end
    b = dout;
    c = ach;
    soe = 1'b1;
    repeat (3) @(negedge clk);
    soe = 1'b0;
    repeat ($urandom_range(3, 6)) @(negedge clk);
  endtask

  task automatic exp_word(input string tag, input logic [31:0] w,
                          input logic ch);
    logic [7:0] b;
    logic       c;
    for (int k = 3; k >= 0; k--) begin
      read_byte(b, c);
      chk({tag, "_byte"}, b, w[8*k +: 8]);
      chk({tag, "_ch"}, c, ch);
    end
  endtask

  task automatic exp_hdr(input string tag, input logic ch);
`ifdef SMI_ARB_HEADER_EN
    logic [7:0] b;
    logic [7:0] h;
    logic       c;
    read_byte(b, c);
    h = {4'hA, 3'b000, ch};
    chk(tag, b, h);
`endif
  endtask

  // Reference: expected byte stream from queue contents and round-robin rules.
  task automatic build_expect();
    bit          ch;
    int          n;
    logic [31:0] w;
    while (m09.size() > 0 || m24.size() > 0) begin
      if (m09.size() > 0 && m24.size() > 0) ch = !mlg;
      else ch = (m24.size() > 0);
      mlg = ch;
`ifdef SMI_ARB_HEADER_EN
      eb.push_back({4'hA, 3'b000, ch});
      ec.push_back(ch);
`endif
      n = 0;
      while (n < BW && (ch ? m24.size() : m09.size()) > 0) begin
        w = ch ? m24.pop_front() : m09.pop_front();
        for (int k = 3; k >= 0; k--) begin
          eb.push_back(w[8*k +: 8]);
          ec.push_back(ch);
        end
        n++;
      end
    end
  endtask

  initial begin
    logic [7:0] b;
    logic       c;
    int         p0, p1, n0, n1;
    logic [31:0] w;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_data", dout, 8'h00);
    chk("rst_req", rreq, 1'b0);
    chk("rst_ch", ach, 1'b0);
    chk("rst_uerr", uerr, 1'b0);
    chk("rst_pulls", {p09, p24}, 2'b00);
    rst = 1'b0;
    en  = 1'b1;
    repeat (2) @(negedge clk);

    // Underrun while idle and empty
    soe = 1'b1;
    repeat (3) @(negedge clk);
    soe = 1'b0;
    repeat (4) @(negedge clk);
    chk("underrun_set", uerr, 1'b1);
    chk("underrun_idle_req", rreq, 1'b0);
    chk("underrun_data", dout, 8'h00);

    // Single word from 0.9 GHz
    p0 = pulls09;
    push09(32'h11223344);
    exp_hdr("basic_hdr", 1'b0);
    exp_word("basic", 32'h11223344, 1'b0);
    repeat (10) @(negedge clk);
    chk("basic_pulls", pulls09 - p0, 1);
    chk("basic_idle_req", rreq, 1'b0);
    chk("basic_idle_data", dout, 8'h00);
    chk("underrun_sticky", uerr, 1'b1);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("underrun_clr", uerr, 1'b0);

    // Single word from 2.4 GHz
    push24(32'hDEADBEEF);
    exp_hdr("beef_hdr", 1'b1);
    exp_word("beef", 32'hDEADBEEF, 1'b1);

    // Enable dropped mid-word
    p0 = pulls09;
    push09(32'hAABBCCDD);
    push09(32'h01020304);
    exp_hdr("en_hdr", 1'b0);
    read_byte(b, c);
    chk("en_b0", b, 8'hAA);
    read_byte(b, c);
    chk("en_b1", b, 8'hBB);
    en = 1'b0;
    read_byte(b, c);
    chk("en_b2", b, 8'hCC);
    read_byte(b, c);
    chk("en_b3", b, 8'hDD);
    repeat (20) @(negedge clk);
    chk("en_idle_req", rreq, 1'b0);
    chk("en_pulls", pulls09 - p0, 1);
    chk("en_left", e09, 1'b0);
    wr09 = rd09;
    en = 1'b1;

    // Reset mid-word: last grant was 0.9, so the tie goes to 2.4 first
    push09(32'h55667788);
    push09(32'h99AABBCC);
    push24(32'h0F1E2D3C);
    push24(32'h4B5A6978);
    exp_hdr("mid_hdr", 1'b1);
    read_byte(b, c);
    chk("mid_b0", b, 8'h0F);
    chk("mid_ch", c, 1'b1);
    read_byte(b, c);
    chk("mid_b1", b, 8'h1E);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_data", dout, 8'h00);
    chk("mid_rst_req", rreq, 1'b0);
    chk("mid_rst_ch", ach, 1'b0);
    chk("mid_rst_pulls", {p09, p24}, 2'b00);
    rst = 1'b0;
    exp_hdr("post_rst_hdr", 1'b0);
    read_byte(b, c);
    chk("post_rst_b0", b, 8'h55);
    chk("post_rst_ch", c, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    wr09 = rd09;
    wr24 = rd24;
    rst = 1'b0;
    @(negedge clk);

    // Random bursts against the reference stream
    mlg = 1'b1;
    for (int r = 0; r < 8; r++) begin
      n0 = $urandom_range(0, 4);
      n1 = $urandom_range(0, 4);
      p0 = pulls09;
      p1 = pulls24;
      for (int i = 0; i < n0; i++) begin
        w = $urandom;
        push09(w);
        m09.push_back(w);
      end
      for (int i = 0; i < n1; i++) begin
        w = $urandom;
        push24(w);
        m24.push_back(w);
      end
      build_expect();
      while (eb.size() > 0) begin
        read_byte(b, c);
        chk("rnd_byte", b, eb.pop_front());
        chk("rnd_ch", c, ec.pop_front());
      end
      repeat (10) @(negedge clk);
      chk("rnd_idle_req", rreq, 1'b0);
      chk("rnd_pulls09", pulls09 - p0, n0);
      chk("rnd_pulls24", pulls24 - p1, n1);
    end

    chk("no_empty_pull", bad_pulls, 0);
    chk("final_uerr", uerr, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/smi_rx_arbiter.md
Name: smi_rx_arbiter

Overview:
Shares the single SMI read channel between the 0.9 GHz and 2.4 GHz RX FIFOs.
- Grants bursts of 32-bit words round-robin.
- Pulls one word at a time from the granted FIFO and serializes it MSB-byte-first onto the SMI data bus, advancing on each SOE strobe.
- Sits between the two RX FIFOs and the SMI pad logic; replaces per-address data selection.

Parameters:
BURST_WORDS, 16, max words sent from one channel per grant before re-arbitration (1..64)
WORD_W, 32, FIFO word width; fixed at 4 bytes

Ports:
i_sys_clk  in  1  FPGA system clock
i_reset  in  1  synchronous, active-high reset
i_enable  in  1  allow new grants; low = finish current word, then idle
i_fifo_09_empty  in  1  0.9 GHz FIFO empty flag
i_fifo_09_data  in  32  0.9 GHz FIFO read data, valid 1 cycle after pull
o_fifo_09_pull  out  1  single-cycle pop strobe, 0.9 GHz FIFO
i_fifo_24_empty  in  1  2.4 GHz FIFO empty flag
i_fifo_24_data  in  32  2.4 GHz FIFO read data, valid 1 cycle after pull
o_fifo_24_pull  out  1  single-cycle pop strobe, 2.4 GHz FIFO
i_smi_soe_se  in  1  async SMI output-enable strobe from host
o_smi_data_out  out  8  byte presented to host
o_smi_read_req  out  1  byte valid / data pending
o_active_ch  out  1  current grant: 0 = 0.9 GHz, 1 = 2.4 GHz
o_underrun_err  out  1  sticky: host strobed with no valid byte

Behaviour:
Reset:
- Applies in any state, mid-burst included; the partially sent word is dropped.
- Outputs: o_smi_data_out=0, both pulls=0, o_smi_read_req=0, o_active_ch=0, o_underrun_err=0.
- Internal: state=IDLE, last_grant=1 (first tie goes to 0.9), byte_idx=3, burst_cnt=0.

SOE synchronisation:
- 2-flop synchroniser q1, q2.
- soe_rise = q1 & ~q2, i.e. 2 cycles after the pin rises.
- A byte is consumed on each soe_rise.

States:
- IDLE
  - Needs i_enable=1 and at least one FIFO non-empty.
  - Both non-empty: grant ~last_grant. Only one non-empty: grant that one.
  - Set o_active_ch and last_grant; burst_cnt=0; go PULL.
- PULL
  - Exactly 1 cycle; assert the granted pull only; burst_cnt+1; go LOAD.
- LOAD
  - Capture the granted data word into the shift register.
  - o_smi_data_out=word[31:24], byte_idx=3, o_smi_read_req=1; go SHIFT.
  - From the pull cycle, the first byte is valid 2 cycles later.
- SHIFT, on soe_rise:
  - byte_idx>0: byte_idx-1, present the next lower byte (31:24, 23:16, 15:8, 7:0) on the following cycle.
  - byte_idx==0, continue: burst_cnt<BURST_WORDS, granted FIFO non-empty, i_enable=1. Go PULL, same channel.
  - byte_idx==0, otherwise: drop o_smi_read_req, o_smi_data_out=0, go IDLE.
  - Word boundary: read_req is low from the last-byte soe_rise through the PULL cycle; high again at LOAD.

Underrun:
- soe_rise while not in SHIFT (IDLE/PULL/LOAD) sets o_underrun_err.
- Sticky until reset; o_smi_data_out stays 0; state unaffected.

Boundaries:
- Empty flag is sampled only in IDLE and at word boundaries. No pull is ever issued to an empty FIFO.
- burst_cnt width covers up to 64.
- i_enable deasserting mid-word does not truncate the word.

Optional Feature:
Macro: SMI_ARB_HEADER_EN
- Defined:
  - HEADER state is inserted between the IDLE grant and the first PULL of each burst.
  - It presents byte {4'hA, 3'b000, ch} with o_smi_read_req=1.
  - It is consumed by one soe_rise and leaves to PULL.
  - The host uses it to demultiplex channels.
- Undefined: HEADER state and its logic are absent; bursts start directly with data bytes.

Test Plan:
- 0.9 FIFO holds 32'h11223344, 2.4 empty, enable=1, 4 SOE pulses -> bytes 11,22,33,44 in order; one 09 pull pulse; o_active_ch=0; then IDLE, read_req=0.
- Both FIFOs hold 3 words, BURST_WORDS=2 -> 2 words from ch0, then 2 from ch1, then 1 from ch0, then 1 from ch1; no pull while empty=1.
- SOE pulse while IDLE with both FIFOs empty -> o_underrun_err=1, stays 1 through later valid traffic until i_reset.
- i_enable dropped after the 2nd byte of a word -> remaining 2 bytes still delivered; no further pull; IDLE.
- i_reset asserted mid-word (byte_idx=1) -> next cycle all outputs 0, last_grant=1; after release both non-empty -> ch0 granted.
- SMI_ARB_HEADER_EN defined, 2.4 FIFO holds 32'hDEADBEEF -> bytes A1,DE,AD,BE,EF.
